// File: rtl/trap_ctrl_if.sv
// Signal bundle between the M stage / CSR file and the trap controller.
// The slave modport is the controller's view; master is the pipeline side.
interface trap_ctrl_if;
    logic [31:0] pc_m;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic        irq_ext;
    logic        irq_timer;
    logic        mret;
    logic [31:0] mstatus_i;
    logic [31:0] mie_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        csr_wr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        stall;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    modport slave (
        input  pc_m, exc_valid, exc_code, irq_ext, irq_timer, mret,
        input  mstatus_i, mie_i, mtvec_i, mepc_i,
        output csr_wr_en, csr_addr, csr_wdata,
        output stall, flush, pc_redirect, redirect_pc, busy
    );

    modport master (
        output pc_m, exc_valid, exc_code, irq_ext, irq_timer, mret,
        output mstatus_i, mie_i, mtvec_i, mepc_i,
        input  csr_wr_en, csr_addr, csr_wdata,
        input  stall, flush, pc_redirect, redirect_pc, busy
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer: serialises mepc/mcause/mstatus writes, then redirects the PC.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets (mtvec mode 2'b01).
module trap_ctrl (
    input  logic        clk,
    input  logic        reset,
    trap_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WR_EPC      = 3'd1,
        WR_CAUSE    = 3'd2,
        WR_STATUS   = 3'd3,
        MRET_STATUS = 3'd4,
        REDIRECT    = 3'd5
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] target_q, target_d;

    logic        take_ext_s;
    logic        take_tim_s;
    logic [31:0] base_s;
    logic [31:0] trap_vec_s;
    logic        csr_wr_en_s;
    logic [11:0] csr_addr_s;
    logic [31:0] csr_wdata_s;
    logic        stall_s;
    logic        flush_s;
    logic        pc_redirect_s;
    logic [31:0] redirect_pc_s;
    logic        unused_s;

    function automatic logic [31:0] status_on_trap(input logic [31:0] m);
        logic [31:0] r;
        r        = m;
        r[12:11] = 2'b11;
        r[7]     = m[3];
        r[3]     = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] status_on_mret(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[3] = m[7];
        r[7] = 1'b1;
        return r;
    endfunction

    assign take_ext_s = bus.mstatus_i[3] & bus.irq_ext   & bus.mie_i[11];
    assign take_tim_s = bus.mstatus_i[3] & bus.irq_timer & bus.mie_i[7];
    assign base_s     = {bus.mtvec_i[31:2], 2'b00};
    assign unused_s   = ^{bus.mie_i[31:12], bus.mie_i[10:8], bus.mie_i[6:0], bus.mtvec_i[1:0]};

    // Trap target: base, or base + 4*code for vectored interrupts when enabled.
    always_comb begin
        trap_vec_s = base_s;
`ifdef TRAP_VECTORED_EN
        if (cause_q[31] && (bus.mtvec_i[1:0] == 2'b01)) begin
            trap_vec_s = base_s + {26'd0, cause_q[3:0], 2'b00};
        end else begin
            trap_vec_s = base_s;
        end
`endif
    end

    // Next-state, latch updates and per-state outputs.
    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        target_d      = target_q;
        csr_wr_en_s   = 1'b0;
        csr_addr_s    = 12'h000;
        csr_wdata_s   = 32'h0000_0000;
        stall_s       = 1'b0;
        flush_s       = 1'b0;
        pc_redirect_s = 1'b0;
        redirect_pc_s = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                if (bus.exc_valid) begin
                    epc_d   = bus.pc_m;
                    cause_d = {1'b0, 27'd0, bus.exc_code};
                    state_d = WR_EPC;
                    stall_s = 1'b1;
                end else if (take_ext_s) begin
                    epc_d   = bus.pc_m;
                    cause_d = {1'b1, 27'd0, 4'd11};
                    state_d = WR_EPC;
                    stall_s = 1'b1;
                end else if (take_tim_s) begin
                    epc_d   = bus.pc_m;
                    cause_d = {1'b1, 27'd0, 4'd7};
                    state_d = WR_EPC;
                    stall_s = 1'b1;
                end else if (bus.mret) begin
                    state_d = MRET_STATUS;
                    stall_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_EPC: begin
                csr_wr_en_s = 1'b1;
                csr_addr_s  = CSR_MEPC;
                csr_wdata_s = epc_q;
                stall_s     = 1'b1;
                state_d     = WR_CAUSE;
            end
            WR_CAUSE: begin
                csr_wr_en_s = 1'b1;
                csr_addr_s  = CSR_MCAUSE;
                csr_wdata_s = cause_q;
                stall_s     = 1'b1;
                state_d     = WR_STATUS;
            end
            WR_STATUS: begin
                csr_wr_en_s = 1'b1;
                csr_addr_s  = CSR_MSTATUS;
                csr_wdata_s = status_on_trap(bus.mstatus_i);
                stall_s     = 1'b1;
                target_d    = trap_vec_s;
                state_d     = REDIRECT;
            end
            MRET_STATUS: begin
                csr_wr_en_s = 1'b1;
                csr_addr_s  = CSR_MSTATUS;
                csr_wdata_s = status_on_mret(bus.mstatus_i);
                stall_s     = 1'b1;
                target_d    = bus.mepc_i;
                state_d     = REDIRECT;
            end
            REDIRECT: begin
                pc_redirect_s = 1'b1;
                flush_s       = 1'b1;
                redirect_pc_s = target_q;
                stall_s       = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched trap context.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            epc_q    <= 32'h0000_0000;
            cause_q  <= 32'h0000_0000;
            target_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    // stall is the only input-dependent output, so it alone needs reset gating.
    assign bus.stall       = stall_s & ~reset;
    assign bus.csr_wr_en   = csr_wr_en_s;
    assign bus.csr_addr    = csr_addr_s;
    assign bus.csr_wdata   = csr_wdata_s;
    assign bus.flush       = flush_s;
    assign bus.pc_redirect = pc_redirect_s;
    assign bus.redirect_pc = redirect_pc_s;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: tests push expected CSR writes / redirects with cycle stamps;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_trap_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    trap_ctrl_if bus_if ();

    trap_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        logic        redir;
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t sb_q[$];
    ev_t mon_e;
    logic [31:0] mon_data;
    logic mon_ok;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] EXP_EXT_PC = 32'h0000_022C;
    localparam logic [31:0] EXP_TIM_PC = 32'h0000_021C;
`else
    localparam logic [31:0] EXP_EXT_PC = 32'h0000_0200;
    localparam logic [31:0] EXP_TIM_PC = 32'h0000_0200;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every CSR write or redirect must match the queue head.
    always @(negedge clk) begin
        if (!reset && (bus_if.csr_wr_en || bus_if.pc_redirect)) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_event: cyc=%0d wr=%b addr=%h wdata=%h redir=%b pc=%h, required no event",
                         cyc, bus_if.csr_wr_en, bus_if.csr_addr, bus_if.csr_wdata, bus_if.pc_redirect, bus_if.redirect_pc);
            end else begin
                mon_e    = sb_q.pop_front();
                mon_data = mon_e.redir ? bus_if.redirect_pc : bus_if.csr_wdata;
                mon_ok   = ({bus_if.csr_wr_en, bus_if.pc_redirect, bus_if.flush} === {~mon_e.redir, mon_e.redir, mon_e.redir})
                           && (mon_e.redir || (bus_if.csr_addr === mon_e.addr))
                           && (mon_data === mon_e.data) && (cyc == mon_e.cyc);
                if (mon_ok) begin
                    n_pass++;
                end else begin
                    $display("FAIL sb_event: got cyc=%0d wr=%b redir=%b flush=%b addr=%h data=%h, required cyc=%0d redir=%b addr=%h data=%h",
                             cyc, bus_if.csr_wr_en, bus_if.pc_redirect, bus_if.flush, bus_if.csr_addr, mon_data,
                             mon_e.cyc, mon_e.redir, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic r, input logic [11:0] a, input logic [31:0] d, input int c);
        ev_t e;
        e.redir = r;
        e.addr  = a;
        e.data  = d;
        e.cyc   = c;
        sb_q.push_back(e);
    endtask

    task automatic clear_events();
        bus_if.exc_valid = 1'b0;
        bus_if.irq_ext   = 1'b0;
        bus_if.irq_timer = 1'b0;
        bus_if.mret      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.exc_valid = 1'b1;
        bus_if.mret      = 1'b1;
        tick();
        tick();
        n_total++;
        if ({bus_if.csr_wr_en, bus_if.csr_addr, bus_if.csr_wdata, bus_if.stall, bus_if.flush,
             bus_if.pc_redirect, bus_if.redirect_pc, bus_if.busy} !== 80'd0) begin
            $display("FAIL reset_outputs: wr=%b addr=%h wdata=%h stall=%b flush=%b redir=%b pc=%h busy=%b, required all 0",
                     bus_if.csr_wr_en, bus_if.csr_addr, bus_if.csr_wdata, bus_if.stall, bus_if.flush,
                     bus_if.pc_redirect, bus_if.redirect_pc, bus_if.busy);
        end else n_pass++;
        clear_events();
        reset = 1'b0;
        tick();
        #1;
        n_total++;
        if ({bus_if.stall, bus_if.busy} !== 2'b00) begin
            $display("FAIL idle_after_reset: stall=%b busy=%b, required 0 0", bus_if.stall, bus_if.busy);
        end else n_pass++;
        tick();
    endtask

    task automatic test_exception();
        int c;
        bus_if.mstatus_i = 32'h0; bus_if.mtvec_i = 32'h200;
        bus_if.pc_m = 32'h100; bus_if.exc_code = 4'd2; bus_if.exc_valid = 1'b1;
        c = cyc;
        push(1'b0, 12'h341, 32'h100, c + 1);
        push(1'b0, 12'h342, 32'h2, c + 2);
        push(1'b0, 12'h300, 32'h1800, c + 3);
        push(1'b1, 12'h000, 32'h200, c + 4);
        #1;
        n_total++;
        if ({bus_if.stall, bus_if.busy} !== 2'b10) begin
            $display("FAIL exc_detect: stall=%b busy=%b, required 1 0", bus_if.stall, bus_if.busy);
        end else n_pass++;
        tick();
        clear_events();
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_total++;
            if ({bus_if.stall, bus_if.busy} !== 2'b11) begin
                $display("FAIL exc_busy_c%0d: stall=%b busy=%b, required 1 1", k, bus_if.stall, bus_if.busy);
            end else n_pass++;
            tick();
        end
        #1;
        n_total++;
        if ({bus_if.stall, bus_if.busy, 32'(sb_q.size())} !== {2'b00, 32'd0}) begin
            $display("FAIL exc_done: stall=%b busy=%b pending=%0d, required 0 0 0", bus_if.stall, bus_if.busy, sb_q.size());
        end else n_pass++;
        tick();
    endtask

    task automatic test_irq_ext();
        int c;
        bus_if.mstatus_i = 32'h8; bus_if.mie_i = 32'h800; bus_if.mtvec_i = 32'h201;
        bus_if.pc_m = 32'h400; bus_if.irq_ext = 1'b1;
        c = cyc;
        push(1'b0, 12'h341, 32'h400, c + 1);
        push(1'b0, 12'h342, 32'h8000_000B, c + 2);
        push(1'b0, 12'h300, 32'h1880, c + 3);
        push(1'b1, 12'h000, EXP_EXT_PC, c + 4);
        tick();
        clear_events();
        repeat (4) tick();
        n_total++;
        if ({bus_if.busy, 32'(sb_q.size())} !== 33'd0) begin
            $display("FAIL irq_ext_done: busy=%b pending=%0d, required 0 0", bus_if.busy, sb_q.size());
        end else n_pass++;
        tick();
    endtask

    task automatic test_irq_timer();
        int c;
        bus_if.mstatus_i = 32'h8; bus_if.mie_i = 32'h080; bus_if.mtvec_i = 32'h201;
        bus_if.pc_m = 32'h600; bus_if.irq_timer = 1'b1; bus_if.irq_ext = 1'b1;
        c = cyc;
        push(1'b0, 12'h341, 32'h600, c + 1);
        push(1'b0, 12'h342, 32'h8000_0007, c + 2);
        push(1'b0, 12'h300, 32'h1880, c + 3);
        push(1'b1, 12'h000, EXP_TIM_PC, c + 4);
        tick();
        clear_events();
        repeat (4) tick();
        n_total++;
        if ({bus_if.busy, 32'(sb_q.size())} !== 33'd0) begin
            $display("FAIL irq_timer_done: busy=%b pending=%0d, required 0 0", bus_if.busy, sb_q.size());
        end else n_pass++;
        tick();
    endtask

    task automatic test_irq_masked();
        bus_if.mstatus_i = 32'h0; bus_if.mie_i = 32'h880;
        bus_if.irq_ext = 1'b1; bus_if.irq_timer = 1'b1;
        #1;
        n_total++;
        if (bus_if.stall !== 1'b0) begin
            $display("FAIL irq_masked_stall: stall=%b, required 0", bus_if.stall);
        end else n_pass++;
        repeat (4) tick();
        n_total++;
        if (bus_if.busy !== 1'b0) begin
            $display("FAIL irq_masked_busy: busy=%b, required 0", bus_if.busy);
        end else n_pass++;
        clear_events();
        tick();
    endtask

    task automatic test_priority();
        int c;
        bus_if.mstatus_i = 32'h8; bus_if.mie_i = 32'h880; bus_if.mtvec_i = 32'h301;
        bus_if.pc_m = 32'h700; bus_if.exc_code = 4'd5;
        bus_if.exc_valid = 1'b1; bus_if.irq_timer = 1'b1; bus_if.irq_ext = 1'b1; bus_if.mret = 1'b1;
        c = cyc;
        push(1'b0, 12'h341, 32'h700, c + 1);
        push(1'b0, 12'h342, 32'h5, c + 2);
        push(1'b0, 12'h300, 32'h1880, c + 3);
        push(1'b1, 12'h000, 32'h300, c + 4);
        tick();
        clear_events();
        repeat (4) tick();
        n_total++;
        if ({bus_if.busy, 32'(sb_q.size())} !== 33'd0) begin
            $display("FAIL priority_done: busy=%b pending=%0d, required 0 0", bus_if.busy, sb_q.size());
        end else n_pass++;
        tick();
    endtask

    task automatic test_mret();
        int c;
        bus_if.mstatus_i = 32'h80; bus_if.mie_i = 32'h0; bus_if.mepc_i = 32'h104; bus_if.mret = 1'b1;
        c = cyc;
        push(1'b0, 12'h300, 32'h88, c + 1);
        push(1'b1, 12'h000, 32'h104, c + 2);
        #1;
        n_total++;
        if ({bus_if.stall, bus_if.busy} !== 2'b10) begin
            $display("FAIL mret_detect: stall=%b busy=%b, required 1 0", bus_if.stall, bus_if.busy);
        end else n_pass++;
        tick();
        clear_events();
        #1;
        n_total++;
        if ({bus_if.stall, bus_if.busy} !== 2'b11) begin
            $display("FAIL mret_status: stall=%b busy=%b, required 1 1", bus_if.stall, bus_if.busy);
        end else n_pass++;
        tick();
        bus_if.mepc_i = 32'hDEAD_0000;
        #1;
        n_total++;
        if ({bus_if.stall, bus_if.busy} !== 2'b11) begin
            $display("FAIL mret_redirect: stall=%b busy=%b, required 1 1", bus_if.stall, bus_if.busy);
        end else n_pass++;
        tick();
        #1;
        n_total++;
        if ({bus_if.stall, bus_if.busy, 32'(sb_q.size())} !== {2'b00, 32'd0}) begin
            $display("FAIL mret_done: stall=%b busy=%b pending=%0d, required 0 0 0", bus_if.stall, bus_if.busy, sb_q.size());
        end else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int c;
        bus_if.mstatus_i = 32'h0; bus_if.mtvec_i = 32'h200;
        bus_if.pc_m = 32'h100; bus_if.exc_code = 4'd1; bus_if.exc_valid = 1'b1;
        c = cyc;
        push(1'b0, 12'h341, 32'h100, c + 1);
        push(1'b0, 12'h342, 32'h1, c + 2);
        push(1'b0, 12'h300, 32'h1800, c + 3);
        push(1'b1, 12'h000, 32'h200, c + 4);
        push(1'b0, 12'h341, 32'h500, c + 6);
        push(1'b0, 12'h342, 32'h3, c + 7);
        push(1'b0, 12'h300, 32'h1800, c + 8);
        push(1'b1, 12'h000, 32'h200, c + 9);
        tick();
        bus_if.pc_m = 32'h500; bus_if.exc_code = 4'd3; bus_if.mret = 1'b1;
        repeat (4) tick();
        #1;
        n_total++;
        if ({bus_if.stall, bus_if.busy} !== 2'b10) begin
            $display("FAIL b2b_retake: stall=%b busy=%b, required 1 0", bus_if.stall, bus_if.busy);
        end else n_pass++;
        tick();
        clear_events();
        repeat (4) tick();
        n_total++;
        if ({bus_if.busy, 32'(sb_q.size())} !== 33'd0) begin
            $display("FAIL b2b_done: busy=%b pending=%0d, required 0 0", bus_if.busy, sb_q.size());
        end else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int c;
        bus_if.mstatus_i = 32'h0; bus_if.mtvec_i = 32'h200;
        bus_if.pc_m = 32'h100; bus_if.exc_code = 4'd2; bus_if.exc_valid = 1'b1;
        c = cyc;
        push(1'b0, 12'h341, 32'h100, c + 1);
        tick();
        clear_events();
        tick();
        n_total++;
        if ({bus_if.csr_wr_en, bus_if.csr_addr} !== {1'b1, 12'h342}) begin
            $display("FAIL mid_in_cause: wr=%b addr=%h, required 1 342", bus_if.csr_wr_en, bus_if.csr_addr);
        end else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({bus_if.csr_wr_en, bus_if.csr_addr, bus_if.csr_wdata, bus_if.stall, bus_if.flush,
             bus_if.pc_redirect, bus_if.redirect_pc, bus_if.busy} !== 80'd0) begin
            $display("FAIL mid_reset_outputs: wr=%b addr=%h wdata=%h stall=%b busy=%b, required all 0",
                     bus_if.csr_wr_en, bus_if.csr_addr, bus_if.csr_wdata, bus_if.stall, bus_if.busy);
        end else n_pass++;
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        n_total++;
        if ({bus_if.busy, 32'(sb_q.size())} !== 33'd0) begin
            $display("FAIL mid_after_release: busy=%b pending=%0d, required 0 0", bus_if.busy, sb_q.size());
        end else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        bus_if.pc_m = 32'h0; bus_if.exc_code = 4'd0;
        bus_if.mstatus_i = 32'h0; bus_if.mie_i = 32'h0;
        bus_if.mtvec_i = 32'h0; bus_if.mepc_i = 32'h0;
        clear_events();
        test_reset();
        test_exception();
        test_irq_ext();
        test_irq_timer();
        test_irq_masked();
        test_priority();
        test_mret();
        test_back_to_back();
        test_reset_mid();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high reset.
REQ-002 The block SHALL have ports: pc_m  in  32  PC of the instruction in M stage; exc_valid  in  1  synchronous exception on that instruction; exc_code  in  4  exception cause code.
REQ-003 The block SHALL have ports: irq_ext  in  1  external interrupt line (level); irq_timer  in  1  timer interrupt line (level); mret  in  1  MRET in M stage.
REQ-004 The block SHALL have ports: mstatus_i, mie_i, mtvec_i, mepc_i  in  32 each  current CSR contents.
REQ-005 The block SHALL have ports: csr_wr_en  out  1; csr_addr  out  12; csr_wdata  out  32  CSR write port into the CSR register file.
REQ-006 The block SHALL have ports: stall  out  1  hold pipeline; flush  out  1  squash F/D/E; pc_redirect  out  1  PC load strobe; redirect_pc  out  32  new PC; busy  out  1  FSM not IDLE.

Function
REQ-007 The FSM SHALL have states IDLE, WR_EPC, WR_CAUSE, WR_STATUS, MRET_STATUS and REDIRECT.
REQ-008 In IDLE, take = exc_valid | (mstatus_i[3] & ((irq_ext & mie_i[11]) | (irq_timer & mie_i[7]))).
REQ-009 Priority SHALL be exception > external > timer > mret; lower-priority events in the same cycle are dropped (mret not executed; interrupts remain pending by level).
REQ-010 On take, the block SHALL latch epc_q=pc_m and cause_q={int,27'b0,code} (exception: int=0, code=exc_code; external: 1, 11; timer: 1, 7), then go to WR_EPC.
REQ-011 On mret with no take, the block SHALL go to MRET_STATUS.
REQ-012 WR_EPC: csr_wr_en=1, csr_addr=0x341, csr_wdata=epc_q; next WR_CAUSE.
REQ-013 WR_CAUSE: csr_wr_en=1, csr_addr=0x342, csr_wdata=cause_q; next WR_STATUS.
REQ-014 WR_STATUS: csr_wr_en=1, csr_addr=0x300, csr_wdata=mstatus_i with bit7(MPIE)=mstatus_i[3], bit3(MIE)=0, bits[12:11](MPP)=2'b11; next REDIRECT with target=trap vector.
REQ-015 MRET_STATUS: csr_wr_en=1, csr_addr=0x300, csr_wdata=mstatus_i with bit3=mstatus_i[7], bit7=1; next REDIRECT with target=mepc_i, sampled in this state.
REQ-016 REDIRECT: pc_redirect=1, flush=1, redirect_pc=target register, held for exactly one cycle; next IDLE.
REQ-017 stall SHALL be asserted combinationally in the IDLE cycle in which take or mret is detected, and in every non-IDLE state including REDIRECT.
REQ-018 Trap latency SHALL be 4 cycles from detection to the REDIRECT strobe; MRET latency SHALL be 2 cycles.
REQ-019 exc_valid, mret and irq lines SHALL be ignored while busy; a new trap can be taken in the cycle after REDIRECT.
REQ-020 When idle, outputs SHALL be: csr_wr_en=0, csr_addr=0, csr_wdata=0, pc_redirect=0, flush=0.
REQ-021 Trap vector base SHALL be {mtvec_i[31:2],2'b00}; all address arithmetic is 32-bit and wraps modulo 2^32.

Reset
REQ-022 Asserting reset at any time, including mid-sequence, SHALL force the FSM to IDLE and clear epc_q, cause_q and target to 0 immediately.
REQ-023 During reset all outputs SHALL be 0, and no partial CSR write sequence SHALL resume after release.

Configuration
REQ-024 With macro TRAP_VECTORED_EN defined, interrupts when mtvec_i[1:0]==2'b01 SHALL redirect to base + 4*code (external: base+0x2C, timer: base+0x1C); exceptions always go to base.
REQ-025 Without TRAP_VECTORED_EN, all traps SHALL redirect to base regardless of mtvec_i[1:0].

Verification
REQ-026 exc_valid=1, exc_code=2, pc_m=0x100, mtvec_i=0x200 -> writes 0x341<-0x100, 0x342<-0x2, then 0x300; REDIRECT to 0x200 at cycle 4; stall high for cycles 0-4.
REQ-027 mstatus_i=0x8, mie_i=0x800, irq_ext=1, mtvec_i=0x201 -> mcause 0x8000000B; mstatus write 0x1880; redirect 0x22C with TRAP_VECTORED_EN, 0x200 without.
REQ-028 irq_ext=1 with mstatus_i[3]=0 -> no action, stall=0; exc_valid=1 plus irq_timer in the same cycle -> mcause=exc_code (exception wins).
REQ-029 mret=1, mstatus_i=0x80, mepc_i=0x104 -> 0x300<-0x88; REDIRECT to 0x104 at cycle 2.
REQ-030 reset pulse while in WR_CAUSE -> all outputs 0 immediately, no further CSR writes, busy=0 after release.
